// File: rtl/line_pkg.sv
// Shared types and constants for the line-drawing peripheral: engine states,
// register offsets and a small width helper.
package line_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ORDER,
        INIT,
        DRAW
    } state_t;

    localparam logic [2:0] OFF_X0     = 3'd0;
    localparam logic [2:0] OFF_Y0     = 3'd1;
    localparam logic [2:0] OFF_X1     = 3'd2;
    localparam logic [2:0] OFF_Y1     = 3'd3;
    localparam logic [2:0] OFF_COLOUR = 3'd4;
    localparam logic [2:0] OFF_GO     = 3'd5;
    localparam logic [2:0] OFF_STATUS = 3'd6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_draw_responder_if.sv
// Processor data-bus port seen by the line-drawing peripheral: select, offset,
// write strobe, write data and combinational read data.
interface line_draw_responder_if;

    logic        Sel;
    logic [2:0]  ADDR;
    logic        W;
    logic [15:0] DOUT;
    logic [15:0] RDATA;

    modport master (output Sel, ADDR, W, DOUT, input RDATA);
    modport slave  (input Sel, ADDR, W, DOUT, output RDATA);

endinterface

// File: rtl/line_engine.sv
// Bresenham engine: snapshots endpoints on start, normalises to a shallow
// left-to-right line, then emits one registered pixel per clock.
module line_engine
    import line_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          plot,
    output logic          busy
);

    localparam int WW = max_int(XW, YW);
    localparam int EW = WW + 2;

    state_t               state;
    logic [WW-1:0]        wx0, wy0, wx1, wy1;
    logic [WW-1:0]        x, y;
    logic [CW-1:0]        col;
    logic                 steep;
    logic                 y_up;
    logic signed [EW-1:0] dx, dy, err;

    logic [WW-1:0]        adx, ady;
    logic                 steep_c;
    logic signed [EW-1:0] dx_c, dy_c, err_sub, err_n;
    logic [WW-1:0]        x_n, y_n;

    always_comb begin
        adx     = (wx1 >= wx0) ? wx1 - wx0 : wx0 - wx1;
        ady     = (wy1 >= wy0) ? wy1 - wy0 : wy0 - wy1;
        steep_c = ady > adx;
        dx_c    = EW'(wx1) - EW'(wx0);
        dy_c    = EW'(ady);
        err_sub = err - dy;
        x_n     = x + WW'(1);
        if (err_sub[EW-1]) begin
            y_n   = y_up ? y + WW'(1) : y - WW'(1);
            err_n = err_sub + dx;
        end else begin
            y_n   = y;
            err_n = err_sub;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wx0        <= '0;
            wy0        <= '0;
            wx1        <= '0;
            wy1        <= '0;
            x          <= '0;
            y          <= '0;
            col        <= '0;
            steep      <= 1'b0;
            y_up       <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wx0   <= WW'(x0);
                        wy0   <= WW'(y0);
                        wx1   <= WW'(x1);
                        wy1   <= WW'(y1);
                        col   <= colour;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    steep <= steep_c;
                    // NOTE: swaps need no temporaries because every right-hand side
                    // reads the pre-edge value under non-blocking assignment.
                    if (steep_c) begin
                        wx0 <= wy0;
                        wy0 <= wx0;
                        wx1 <= wy1;
                        wy1 <= wx1;
                    end
                    state <= ORDER;
                end
                ORDER: begin
                    if (wx0 > wx1) begin
                        wx0 <= wx1;
                        wy0 <= wy1;
                        wx1 <= wx0;
                        wy1 <= wy0;
                    end
                    state <= INIT;
                end
                INIT: begin
                    dx         <= dx_c;
                    dy         <= dy_c;
                    err        <= dx_c >>> 1;
                    y_up       <= wy0 < wy1;
                    x          <= wx0;
                    y          <= wy0;
                    pix_x      <= steep ? XW'(wy0) : XW'(wx0);
                    pix_y      <= steep ? YW'(wx0) : YW'(wy0);
                    pix_colour <= col;
                    plot       <= 1'b1;
                    state      <= DRAW;
                end
                DRAW: begin
                    // x/y always hold the pixel currently on the outputs.
                    if (x == wx1) begin
                        plot  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        x     <= x_n;
                        y     <= y_n;
                        err   <= err_n;
                        pix_x <= steep ? XW'(y_n) : XW'(x_n);
                        pix_y <= steep ? YW'(x_n) : YW'(y_n);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/line_draw_responder.sv
// Memory-mapped line-drawing peripheral: register file, write decode and read
// mux in front of the Bresenham engine that drives the frame-buffer port.
module line_draw_responder
    import line_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    line_draw_responder_if.slave  bus,
    output logic [XW-1:0]         VGA_X,
    output logic [YW-1:0]         VGA_Y,
    output logic [CW-1:0]         VGA_COLOUR,
    output logic                  VGA_PLOT,
    output logic                  Busy
);

    logic [XW-1:0] x0_q, x1_q;
    logic [YW-1:0] y0_q, y1_q;
    logic [CW-1:0] colour_q;
    logic          wr;
    logic          go;
    logic [15:0]   rdata;
    logic          unused_dout;

    // Writes are dropped entirely while a line is in flight.
    assign wr          = bus.Sel & bus.W & ~Busy;
    assign go          = wr && (bus.ADDR == OFF_GO);
    assign unused_dout = ^bus.DOUT;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            colour_q <= '0;
        end else if (wr) begin
            case (bus.ADDR)
                OFF_X0:     x0_q     <= bus.DOUT[XW-1:0];
                OFF_Y0:     y0_q     <= bus.DOUT[YW-1:0];
                OFF_X1:     x1_q     <= bus.DOUT[XW-1:0];
                OFF_Y1:     y1_q     <= bus.DOUT[YW-1:0];
                OFF_COLOUR: colour_q <= bus.DOUT[CW-1:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps this mux free of latches.
        rdata = '0;
        case (bus.ADDR)
            OFF_X0:     rdata = 16'(x0_q);
            OFF_Y0:     rdata = 16'(y0_q);
            OFF_X1:     rdata = 16'(x1_q);
            OFF_Y1:     rdata = 16'(y1_q);
            OFF_COLOUR: rdata = 16'(colour_q);
            OFF_STATUS: rdata = {15'b0, Busy};
            default:    rdata = '0;
        endcase
    end

    assign bus.RDATA = rdata;

    line_engine #(
        .XW(XW),
        .YW(YW),
        .CW(CW)
    ) u_engine (
        .clk        (Clock),
        .rst        (Reset),
        .start      (go),
        .x0         (x0_q),
        .y0         (y0_q),
        .x1         (x1_q),
        .y1         (y1_q),
        .colour     (colour_q),
        .pix_x      (VGA_X),
        .pix_y      (VGA_Y),
        .pix_colour (VGA_COLOUR),
        .plot       (VGA_PLOT),
        .busy       (Busy)
    );

endmodule

// File: tb/tb_line_draw_responder.sv
// Directed bench for line_draw_responder: register access, pixel sequences,
// Busy timing, ignored writes while busy and asynchronous reset mid-draw.
module tb_line_draw_responder;
    import line_pkg::*;

    logic       clk;
    logic       rst;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int         cnt, first_idx, last_idx, busy_cnt;
    logic [8:0] cx [16];
    logic [7:0] cy [16];
    logic [2:0] cc [16];
    logic [15:0] rd;

    line_draw_responder_if bus ();

    line_draw_responder #(.XW(9), .YW(8), .CW(3)) dut (
        .Clock      (clk),
        .Reset      (rst),
        .bus        (bus),
        .VGA_X      (vga_x),
        .VGA_Y      (vga_y),
        .VGA_COLOUR (vga_colour),
        .VGA_PLOT   (vga_plot),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.Sel  = 1'b1;
        bus.W    = 1'b1;
        bus.ADDR = a;
        bus.DOUT = d;
        @(posedge clk);
        #1;
        bus.Sel = 1'b0;
        bus.W   = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.ADDR = a;
        #1;
        d = bus.RDATA;
    endtask

    task automatic setup_line(input int x0, input int y0, input int x1, input int y1, input int c);
        do_write(OFF_X0, 16'(x0));
        do_write(OFF_Y0, 16'(y0));
        do_write(OFF_X1, 16'(x1));
        do_write(OFF_Y1, 16'(y1));
        do_write(OFF_COLOUR, 16'(c));
    endtask

    // Samples one negedge per cycle; sample 0 is the cycle right after the GO edge.
    task automatic collect(input int n);
        cnt = 0; first_idx = -1; last_idx = -1; busy_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (vga_plot) begin
                if (cnt < 16) begin
                    cx[cnt] = vga_x;
                    cy[cnt] = vga_y;
                    cc[cnt] = vga_colour;
                end
                if (first_idx < 0) first_idx = k;
                last_idx = k;
                cnt++;
            end
        end
    endtask

    task automatic check_draw(input string tag, input int n_pix);
        check({tag, "_first_plot_cycle"}, first_idx, 3);
        check({tag, "_pixel_count"}, cnt, n_pix);
        check({tag, "_contiguous"}, last_idx - first_idx + 1, n_pix);
        check({tag, "_busy_cycles"}, busy_cnt, 3 + n_pix);
    endtask

    task automatic check_px(input string tag, input int k, input int ex, input int ey, input int ec);
        check($sformatf("%s_pix%0d_x", tag, k), 32'(cx[k]), ex);
        check($sformatf("%s_pix%0d_y", tag, k), 32'(cy[k]), ey);
        check($sformatf("%s_pix%0d_colour", tag, k), 32'(cc[k]), ec);
    endtask

    initial begin
        rst      = 1'b1;
        bus.Sel  = 1'b0;
        bus.W    = 1'b0;
        bus.ADDR = '0;
        bus.DOUT = '0;
        repeat (2) @(negedge clk);
        check("reset_plot", 32'(vga_plot), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_vga_x", 32'(vga_x), 0);
        check("reset_vga_y", 32'(vga_y), 0);
        check("reset_colour", 32'(vga_colour), 0);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            read_reg(3'(a), rd);
            check($sformatf("reset_read_off%0d", a), 32'(rd), 0);
        end

        // Horizontal line (0,0)->(3,0)
        setup_line(0, 0, 3, 0, 1);
        read_reg(OFF_X1, rd);
        check("hline_x1_readback", 32'(rd), 3);
        read_reg(7, rd);
        check("hline_off7_reads0", 32'(rd), 0);
        do_write(OFF_GO, 16'h00AA);
        check("hline_busy_after_go", 32'(busy), 1);
        collect(16);
        check_draw("hline", 4);
        check_px("hline", 0, 0, 0, 1);
        check_px("hline", 1, 1, 0, 1);
        check_px("hline", 2, 2, 0, 1);
        check_px("hline", 3, 3, 0, 1);

        // Reversed shallow line (3,2)->(0,0)
        setup_line(3, 2, 0, 0, 2);
        do_write(OFF_GO, 0);
        collect(16);
        check_draw("rev", 4);
        check_px("rev", 0, 0, 0, 2);
        check_px("rev", 1, 1, 1, 2);
        check_px("rev", 2, 2, 1, 2);
        check_px("rev", 3, 3, 2, 2);

        // Steep line (0,0)->(1,3)
        setup_line(0, 0, 1, 3, 5);
        do_write(OFF_GO, 0);
        collect(16);
        check_draw("steep", 4);
        check_px("steep", 0, 0, 0, 5);
        check_px("steep", 1, 0, 1, 5);
        check_px("steep", 2, 1, 2, 5);
        check_px("steep", 3, 1, 3, 5);

        // Degenerate point
        setup_line(5, 5, 5, 5, 6);
        do_write(OFF_GO, 0);
        collect(12);
        check_draw("point", 1);
        check_px("point", 0, 5, 5, 6);

        // Writes while busy are ignored
        setup_line(0, 0, 7, 0, 3);
        do_write(OFF_GO, 0);
        fork
            collect(24);
            begin
                do_write(OFF_X1, 2);
                read_reg(OFF_STATUS, rd);
                check("busy_status_during", 32'(rd), 1);
                do_write(OFF_GO, 0);
            end
        join
        check_draw("busywr", 8);
        check_px("busywr", 0, 0, 0, 3);
        check_px("busywr", 7, 7, 0, 3);
        read_reg(OFF_STATUS, rd);
        check("busy_status_after", 32'(rd), 0);
        read_reg(OFF_X1, rd);
        check("busy_x1_unchanged", 32'(rd), 7);

        // Asynchronous reset at the third pixel
        do_write(OFF_GO, 0);
        repeat (6) @(negedge clk);
        check("rstmid_plot_before", 32'(vga_plot), 1);
        check("rstmid_x_before", 32'(vga_x), 2);
        #1 rst = 1'b1;
        #1;
        check("rstmid_plot_dropped", 32'(vga_plot), 0);
        check("rstmid_busy_dropped", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            read_reg(3'(a), rd);
            check($sformatf("rstmid_read_off%0d", a), 32'(rd), 0);
        end
        collect(12);
        check("rstmid_no_more_plots", cnt, 0);
        check("rstmid_no_busy", busy_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
